mem_copy_master: RTL and testbench

//  Bus initiator for the CPU memory interface (mem_cmd/mem_addr/write_data/read_data).

---
 rtl/mem_copy_master.sv | 156 +++++++++++++++
 tb/tb_mem_copy_master.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// Bus master that copies a block of words from src_addr to dst_addr with READ/WRITE commands.
// Build option: define CHECKSUM_EN to add a running checksum output port.
module mem_copy_master #(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned AW       = 9,
  parameter int unsigned DW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW-1:0] length,
  output logic          busy,
  output logic          done,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
`ifdef CHECKSUM_EN
  output logic [DW-1:0] checksum,
`endif
  input  logic [DW-1:0] read_data
);

  localparam int unsigned CW = $clog2(READ_LAT + 2);
  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_WRITE = 2'b10;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t        state, state_d;
  logic [1:0]    cmd_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;
  logic          busy_d, done_d;
  logic [AW-1:0] src_q, src_d, dst_q, dst_d, len_q, len_d;
  logic [AW-1:0] idx, idx_d, idx_nxt;
  logic [CW-1:0] rd_cnt, rd_cnt_d;
`ifdef CHECKSUM_EN
  logic [DW-1:0] sum_d;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      mem_cmd    <= CMD_NONE;
      mem_addr   <= '0;
      write_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      idx        <= '0;
      rd_cnt     <= '0;
`ifdef CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      state      <= state_d;
      mem_cmd    <= cmd_d;
      mem_addr   <= addr_d;
      write_data <= wdata_d;
      busy       <= busy_d;
      done       <= done_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      len_q      <= len_d;
      idx        <= idx_d;
      rd_cnt     <= rd_cnt_d;
`ifdef CHECKSUM_EN
      checksum   <= sum_d;
`endif
    end
  end

  // Next state and next output values
  always_comb begin
    state_d  = state;
    cmd_d    = mem_cmd;
    addr_d   = mem_addr;
    wdata_d  = write_data;
    busy_d   = busy;
    done_d   = 1'b0;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    idx_d    = idx;
    rd_cnt_d = rd_cnt;
    idx_nxt  = idx + AW'(1);
`ifdef CHECKSUM_EN
    sum_d    = checksum;
`endif
    unique case (state)
      IDLE: begin
        cmd_d  = CMD_NONE;
        busy_d = 1'b0;
        if (start) begin
          src_d  = src_addr;
          dst_d  = dst_addr;
          len_d  = length;
          idx_d  = '0;
          busy_d = 1'b1;
`ifdef CHECKSUM_EN
          sum_d  = '0;
`endif
          if (length != '0) begin
            state_d  = RD;
            cmd_d    = CMD_READ;
            addr_d   = src_addr;
            rd_cnt_d = '0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
      RD: begin
        // READ stays on the bus until the read data has been captured
        if (rd_cnt == CW'(READ_LAT)) begin
          state_d = WR;
          cmd_d   = CMD_WRITE;
          addr_d  = dst_q + idx;
          wdata_d = read_data;
`ifdef CHECKSUM_EN
          sum_d   = checksum + read_data;
`endif
        end else begin
          rd_cnt_d = rd_cnt + CW'(1);
        end
      end
      WR: begin
        idx_d = idx_nxt;
        if (idx_nxt == len_q) begin
          state_d = DONE;
          cmd_d   = CMD_NONE;
          done_d  = 1'b1;
        end else begin
          state_d  = RD;
          cmd_d    = CMD_READ;
          addr_d   = src_q + idx_nxt;
          rd_cnt_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
        cmd_d   = CMD_NONE;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master: RAM model, transaction-level expected bus trace, literal checks.
module tb_mem_copy_master;

  localparam int unsigned RL = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [8:0]  src_addr = '0, dst_addr = '0, length = '0;
  logic        busy, done;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] write_data, read_data;
`ifdef CHECKSUM_EN
  logic [15:0] checksum;
`endif

  mem_copy_master #(.READ_LAT(RL), .AW(9), .DW(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .mem_cmd(mem_cmd), .mem_addr(mem_addr),
    .write_data(write_data),
`ifdef CHECKSUM_EN
    .checksum(checksum),
`endif
    .read_data(read_data)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM; data only driven while READ is on the bus
  logic [15:0] ram [0:511];
  logic [15:0] rd_q = '0;
  logic        poke_en = 1'b0;
  logic [8:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (mem_cmd == 2'b10) ram[mem_addr] <= write_data;
    if (mem_cmd == 2'b01) rd_q <= ram[mem_addr];
  end
  assign read_data = (mem_cmd == 2'b01) ? rd_q : 16'hDEAD;

  int tests = 0, fails = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle bus view, built from the copy rules
  typedef struct packed {
    logic [1:0]  cmd;
    logic [8:0]  addr;
    logic [15:0] wd;
    logic        busy;
    logic        done;
    logic        chk_addr;
  } exp_t;
  exp_t exp_q[$];
  logic [15:0] model_mem [0:511];
  logic [8:0]  rd_log[$];
  logic [1:0]  prev_cmd = 2'b00;
  int          done_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    e = '{cmd: 2'b00, addr: '0, wd: '0, busy: 1'b0, done: 1'b0, chk_addr: 1'b0};
    if (exp_q.size() > 0) e = exp_q.pop_front();
    chk("bus_ctl", {28'd0, mem_cmd, busy, done}, {28'd0, e.cmd, e.busy, e.done});
    if (e.chk_addr) chk("bus_addr", 32'(mem_addr), 32'(e.addr));
    if (e.cmd == 2'b10) chk("write_data", 32'(write_data), 32'(e.wd));
    if (done) done_cnt++;
    if (mem_cmd == 2'b01 && prev_cmd != 2'b01) rd_log.push_back(mem_addr);
    prev_cmd = mem_cmd;
  end

  task automatic poke(input logic [8:0] a, input logic [15:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    model_mem[a] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // Drive one start pulse and append the expected bus trace of the whole copy
  task automatic do_start(input logic [8:0] s, input logic [8:0] d, input logic [8:0] n);
    logic [15:0] w;
    logic [8:0]  sa, da;
    start = 1'b1; src_addr = s; dst_addr = d; length = n;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      sa = s + 9'(i);
      da = d + 9'(i);
      w = model_mem[sa];
      for (int k = 0; k <= int'(RL); k++)
        exp_q.push_back('{cmd: 2'b01, addr: sa, wd: '0, busy: 1'b1, done: 1'b0, chk_addr: 1'b1});
      exp_q.push_back('{cmd: 2'b10, addr: da, wd: w, busy: 1'b1, done: 1'b0, chk_addr: 1'b1});
      model_mem[da] = w;
    end
    exp_q.push_back('{cmd: 2'b00, addr: '0, wd: '0, busy: 1'b1, done: 1'b1, chk_addr: 1'b0});
  endtask

  // Count cycles (cycle 0 = the cycle start was high) until done, bounded
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (done) break;
    end
    if (cyc >= 2000) begin
      tests++; fails++;
      $display("FAIL done_timeout: got no done expected done within 2000 cycles");
    end
  endtask

  initial begin
    int cyc, dc;
    for (int i = 0; i < 512; i++) model_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd",  32'(mem_cmd), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wd",   32'(write_data), 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    for (int i = 0; i < 512; i++) poke(9'(i), 16'h0000);
    poke(9'h010, 16'h1111); poke(9'h011, 16'h2222);
    poke(9'h012, 16'h3333); poke(9'h013, 16'h4444);
    poke(9'h1FE, 16'h5A01); poke(9'h1FF, 16'h5A02);
    poke(9'h000, 16'h5A03); poke(9'h001, 16'h5A04);
    poke(9'h070, 16'h7777);
    poke(9'h020, 16'h00A1); poke(9'h021, 16'h00B2); poke(9'h022, 16'h00C3);
    reset = 1'b0;
    @(posedge clk); #1;

    // T1 basic copy and done timing
    do_start(9'h010, 9'h040, 9'd4);
    wait_done(cyc);
    chk("t1_done_cycle", 32'(cyc), 32'd13);
    chk("t1_done_model", 32'(cyc), 32'(1 + 4 * (RL + 2)));
    repeat (3) @(posedge clk); #1;
    chk("t1_ram40", 32'(ram[9'h040]), 32'h1111);
    chk("t1_ram41", 32'(ram[9'h041]), 32'h2222);
    chk("t1_ram42", 32'(ram[9'h042]), 32'h3333);
    chk("t1_ram43", 32'(ram[9'h043]), 32'h4444);
`ifdef CHECKSUM_EN
    chk("t6_checksum", 32'(checksum), 32'hAAAA);
`endif

    // T2 zero length
    do_start(9'h010, 9'h050, 9'd0);
    wait_done(cyc);
    chk("t2_done_cycle", 32'(cyc), 32'd1);
    repeat (3) @(posedge clk); #1;
    chk("t2_ram50", 32'(ram[9'h050]), 32'h0000);

    // T3 address wrap
    rd_log.delete();
    do_start(9'h1FE, 9'h0A0, 9'd4);
    wait_done(cyc);
    repeat (3) @(posedge clk); #1;
    chk("t3_nreads", 32'(rd_log.size()), 32'd4);
    if (rd_log.size() == 4) begin
      chk("t3_rd0", 32'(rd_log[0]), 32'h1FE);
      chk("t3_rd1", 32'(rd_log[1]), 32'h1FF);
      chk("t3_rd2", 32'(rd_log[2]), 32'h000);
      chk("t3_rd3", 32'(rd_log[3]), 32'h001);
    end
    chk("t3_ram_a2", 32'(ram[9'h0A2]), 32'h5A03);

    // T4 start ignored while busy
    dc = done_cnt;
    do_start(9'h010, 9'h060, 9'd4);
    repeat (3) @(posedge clk); #1;
    start = 1'b1; src_addr = 9'h100; dst_addr = 9'h070; length = 9'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(cyc);
    repeat (6) @(posedge clk); #1;
    chk("t4_done_pulses", 32'(done_cnt - dc), 32'd1);
    chk("t4_ram60", 32'(ram[9'h060]), 32'h1111);
    chk("t4_ram63", 32'(ram[9'h063]), 32'h4444);
    chk("t4_ram70", 32'(ram[9'h070]), 32'h7777);

    // Overlap with dst>src propagates the first word
    do_start(9'h020, 9'h021, 9'd3);
    wait_done(cyc);
    repeat (3) @(posedge clk); #1;
    chk("ovl_ram21", 32'(ram[9'h021]), 32'h00A1);
    chk("ovl_ram22", 32'(ram[9'h022]), 32'h00A1);
    chk("ovl_ram23", 32'(ram[9'h023]), 32'h00A1);

    // T5 reset during third word read
    dc = done_cnt;
    do_start(9'h010, 9'h090, 9'd4);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_pre_cmd", 32'(mem_cmd), 32'd1);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_cmd_async", 32'(mem_cmd), 32'd0);
    chk("t5_busy_async", 32'(busy), 32'd0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("t5_no_done", 32'(done_cnt - dc), 32'd0);
    do_start(9'h010, 9'h0B0, 9'd2);
    wait_done(cyc);
    chk("t5_rerun_cycle", 32'(cyc), 32'd7);
    repeat (3) @(posedge clk); #1;
    chk("t5_ramb0", 32'(ram[9'h0B0]), 32'h1111);
    chk("t5_ramb1", 32'(ram[9'h0B1]), 32'h2222);
`ifdef CHECKSUM_EN
    chk("t6_checksum2", 32'(checksum), 32'h3333);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
